subleq_loader: RTL

//  Boot-time program loader upstream of the subleq core. Accepts a byte stream

---
 rtl/subleq_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/subleq_loader.sv
// subleq_loader: boot-time program loader for the subleq core.
// Receives LEN[7:0], LEN[15:8] (word count N) then N words LSB-first over a
// valid/ready byte stream, writes them from address 0 and holds the core in
// reset until the image is complete.
// Optional trailing XOR checksum byte: define SUBLEQ_LOADER_CHECKSUM_EN.
module subleq_loader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned WORD_W = 64
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [7:0]        iRX_DATA,
  input  logic              iRX_VALID,
  output logic              oRX_READY,
  input  logic              iRELOAD,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [WORD_W-1:0] oMEM_DATA,
  output logic              oMEM_WREN,
  output logic              oCPU_RST,
  output logic              oDONE,
  output logic              oERR
);

  localparam int unsigned BPW = WORD_W / 8;
  localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
  // Compare width wide enough for both the 16-bit count and 2**ADDR_W.
  localparam int unsigned CW  = (ADDR_W + 2 > 17) ? ADDR_W + 2 : 17;
  localparam logic [CW-1:0] MAX_N = CW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     word_q, word_d;
  logic [BIW-1:0]      byte_q, byte_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_full;

  // State register and all datapath flops.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_LEN0;
      len_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state, byte packing and write-port staging.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    data_d  = data_q;

    oRX_READY = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    accept    = iRX_VALID && oRX_READY;
    n_full    = {iRX_DATA, len_q[7:0]};
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    csum_d    = accept ? (csum_q ^ iRX_DATA) : csum_q;
`endif

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = iRX_DATA;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = n_full;
          if (n_full == 16'd0)             state_d = S_TAIL;
          else if (CW'(n_full) > MAX_N)    state_d = S_ERROR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d[{byte_q, 3'b000} +: 8] = iRX_DATA;
          if (byte_q == BIW'(BPW - 1)) begin
            // Address/data are staged on entry so they are valid during WRITE.
            byte_d  = '0;
            addr_d  = word_q[ADDR_W-1:0];
            data_d  = shift_d;
            state_d = S_WRITE;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        word_d  = word_q + 1'b1;
        state_d = (CW'(word_d) == CW'(len_q)) ? S_TAIL : S_DATA;
      end
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (iRX_DATA == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: ;
    endcase

    if (iRELOAD) begin
      state_d = S_LEN0;
      len_d   = '0;
      word_d  = '0;
      byte_d  = '0;
      shift_d = '0;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end

    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERROR);
    cpu_rst_d = (state_d != S_DONE);
  end

  // The strobe is gated by iRELOAD so an abort during WRITE suppresses it.
  assign oMEM_WREN = (state_q == S_WRITE) && !iRELOAD;
  assign oMEM_ADDR = addr_q;
  assign oMEM_DATA = data_q;
  assign oDONE     = done_q;
  assign oERR      = err_q;
  assign oCPU_RST  = cpu_rst_q;

endmodule
